// File: rtl/unpack_arbiter.sv
// unpack_arbiter: packet-level round-robin arbiter that lets N_SRC sources
// share one data_unpack instance. A source is granted on a start-of-packet
// word and keeps the grant until its end-of-packet word is accepted.
//
// Handshake: a word moves on a rising edge when valid and ready are both high
// in that cycle. The source holds its word and flags stable while ready is low.
// src_ready is a combinational function of state, src_valid/src_sop and m_ready.
module unpack_arbiter #(
  parameter  int N_SRC = 4,
  parameter  int DW    = 32,
  localparam int GW    = $clog2(N_SRC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    src_valid,
  input  logic [N_SRC-1:0]    src_sop,
  input  logic [N_SRC-1:0]    src_eop,
  input  logic [N_SRC*DW-1:0] src_data,
  output logic [N_SRC-1:0]    src_ready,
  output logic                m_valid,
  output logic                m_sop,
  output logic                m_eop,
  output logic [DW-1:0]       m_data,
  input  logic                m_ready,
  output logic [GW-1:0]       grant_id,
  output logic                busy,
  input  logic                stat_clr,
  output logic [15:0]         pkt_count,
  output logic [7:0]          drop_count,
  output logic                err_orphan,
  output logic                err_sop
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_q;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   last_q;
  logic            first_q;
  logic [15:0]     pkt_q;
  logic [7:0]      drop_q;
  logic [7:0]      drop_d;
  logic            err_orphan_q;
  logic            err_sop_q;

  logic [DW-1:0]    src_word [N_SRC];
  logic [N_SRC-1:0] cand;
  logic             cand_any;
  logic [GW-1:0]    win;
  logic [GW-1:0]    idx_g;
  logic [N_SRC-1:0] orphan;
  logic [8:0]       drop_sum;
  logic             xfer;

  // Split the flat source data bus into one word per source.
  always_comb begin
    for (int k = 0; k < N_SRC; k++) begin
      src_word[k] = src_data[k*DW +: DW];
    end
  end

  // Round-robin pick among sources offering a start-of-packet word; scanning
  // offsets from high to low lets the smallest offset after last_q win.
  always_comb begin
    cand     = src_valid & src_sop;
    cand_any = |cand;
    win      = '0;
    idx_g    = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      idx_g = GW'((int'(last_q) + 1 + k) % N_SRC);
      if (cand[idx_g]) begin
        win = idx_g;
      end
    end
  end

  // Output mux and ready steering; orphan words are swallowed while idle.
  always_comb begin
    m_valid   = 1'b0;
    m_sop     = 1'b0;
    m_eop     = 1'b0;
    m_data    = '0;
    src_ready = '0;
    orphan    = '0;
    if (state_q == LOCK) begin
      m_valid            = src_valid[grant_q];
      m_sop              = src_sop[grant_q];
      m_eop              = src_eop[grant_q];
      m_data             = src_word[grant_q];
      src_ready[grant_q] = m_ready;
    end else begin
      orphan    = src_valid & ~src_sop;
      src_ready = orphan;
    end
    if (!rst) begin
      src_ready = '0;
    end
  end

  // Saturating add of every orphan word dropped this cycle.
  always_comb begin
    drop_sum = {1'b0, drop_q};
    for (int k = 0; k < N_SRC; k++) begin
      drop_sum = drop_sum + 9'(orphan[k]);
    end
    drop_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    xfer   = m_valid & m_ready;
  end

  // Grant FSM plus statistics; a clear wins over any same-cycle update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= GW'(N_SRC - 1);
      first_q      <= 1'b0;
      pkt_q        <= '0;
      drop_q       <= '0;
      err_orphan_q <= 1'b0;
      err_sop_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cand_any) begin
            state_q <= LOCK;
            grant_q <= win;
            first_q <= 1'b1;
          end
        end
        LOCK: begin
          if (xfer) begin
            first_q <= 1'b0;
            if (m_eop) begin
              state_q <= IDLE;
              last_q  <= grant_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (stat_clr) begin
        pkt_q        <= '0;
        drop_q       <= '0;
        err_orphan_q <= 1'b0;
        err_sop_q    <= 1'b0;
      end else begin
        if (xfer && m_eop) begin
          pkt_q <= pkt_q + 16'd1;
        end
        drop_q <= drop_d;
        if (|orphan) begin
          err_orphan_q <= 1'b1;
        end
        if (xfer && m_sop && !first_q) begin
          err_sop_q <= 1'b1;
        end
      end
    end
  end

  assign grant_id   = grant_q;
  assign busy       = (state_q == LOCK);
  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
  assign err_orphan = err_orphan_q;
  assign err_sop    = err_sop_q;

endmodule

// File: tb/tb_unpack_arbiter.sv
// Directed bench for unpack_arbiter with N_SRC=4, DW=32.
module tb_unpack_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   src_valid;
  logic [3:0]   src_sop;
  logic [3:0]   src_eop;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic         m_valid;
  logic         m_sop;
  logic         m_eop;
  logic [31:0]  m_data;
  logic         m_ready;
  logic [1:0]   grant_id;
  logic         busy;
  logic         stat_clr;
  logic [15:0]  pkt_count;
  logic [7:0]   drop_count;
  logic         err_orphan;
  logic         err_sop;

  int total;
  int bad;
  int npk  [4];
  int plen [4];
  logic [31:0] exp_q [$];
  logic [31:0] gnt_q [$];

  unpack_arbiter #(.N_SRC(4), .DW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_sop    (src_sop),
    .src_eop    (src_eop),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .m_valid    (m_valid),
    .m_sop      (m_sop),
    .m_eop      (m_eop),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .grant_id   (grant_id),
    .busy       (busy),
    .stat_clr   (stat_clr),
    .pkt_count  (pkt_count),
    .drop_count (drop_count),
    .err_orphan (err_orphan),
    .err_sop    (err_sop)
  );

  // clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_src(input int i, input logic v, input logic s, input logic e,
                         input logic [31:0] d);
    src_valid[i]         = v;
    src_sop[i]           = s;
    src_eop[i]           = e;
    src_data[i*32 +: 32] = d;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < 4; i++) set_src(i, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 4; i++) begin
      npk[i]  = 0;
      plen[i] = 1;
    end
  endtask

  // Sources follow their own src_ready; every accepted output word is
  // checked against exp_q and every packet start against gnt_q.
  task automatic run_traffic(input int max_cyc, input bit gap_chk);
    int wi [4];
    int pk [4];
    logic [3:0] fire;
    int cyc;
    int prev;
    for (int i = 0; i < 4; i++) begin
      wi[i] = 0;
      pk[i] = 0;
    end
    cyc  = 0;
    prev = -1;
    while (exp_q.size() > 0 && cyc < max_cyc) begin
      for (int i = 0; i < 4; i++) begin
        if (pk[i] < npk[i])
          set_src(i, 1'b1, wi[i] == 0, wi[i] == plen[i] - 1, {8'(i), 8'(pk[i]), 16'(wi[i])});
        else
          set_src(i, 1'b0, 1'b0, 1'b0, 32'h0);
      end
      #1;
      if (m_valid && m_ready) begin
        if (m_sop) chk("grant_order", 32'(grant_id), gnt_q.pop_front());
        chk("stream_data", m_data, exp_q.pop_front());
        if (gap_chk && prev >= 0) chk("xfer_gap", 32'(cyc - prev), 32'd2);
        prev = cyc;
      end
      fire = src_valid & src_ready;
      tick();
      for (int i = 0; i < 4; i++) begin
        if (fire[i]) begin
          wi[i]++;
          if (wi[i] == plen[i]) begin
            wi[i] = 0;
            pk[i]++;
          end
        end
      end
      cyc++;
    end
    chk("traffic_drained", 32'(exp_q.size()), 32'd0);
    clear_srcs();
  endtask

  // directed sequence
  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b0;
    m_ready  = 1'b1;
    stat_clr = 1'b0;
    clear_srcs();
    clear_plan();

    // reset: outputs forced low even with requests present
    set_src(2, 1'b1, 1'b0, 1'b0, 32'hdead);
    set_src(0, 1'b1, 1'b1, 1'b0, 32'h1234);
    #3;
    chk("rst_src_ready", 32'(src_ready), 32'h0);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    tick();
    tick();
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_pkt", 32'(pkt_count), 32'h0);
    chk("rst_drop", 32'(drop_count), 32'h0);
    chk("rst_errs", {30'h0, err_orphan, err_sop}, 32'h0);
    clear_srcs();
    rst = 1'b1;

    // single 3-word packet from source 0
    set_src(0, 1'b1, 1'b1, 1'b0, 32'h11);
    #1;
    chk("idle_m_valid", 32'(m_valid), 32'h0);
    chk("idle_sop_not_ready", 32'(src_ready), 32'h0);
    tick();
    #1;
    chk("p1_grant", 32'(grant_id), 32'h0);
    chk("p1_busy", 32'(busy), 32'h1);
    chk("p1_w1_data", m_data, 32'h11);
    chk("p1_w1_sop", 32'(m_sop), 32'h1);
    chk("p1_w1_ready", 32'(src_ready), 32'h1);
    tick();
    set_src(0, 1'b1, 1'b0, 1'b0, 32'h22);
    #1;
    chk("p1_w2_data", m_data, 32'h22);
    chk("p1_w2_sop", 32'(m_sop), 32'h0);
    tick();
    set_src(0, 1'b1, 1'b0, 1'b1, 32'h33);
    #1;
    chk("p1_w3_data", m_data, 32'h33);
    chk("p1_w3_eop", 32'(m_eop), 32'h1);
    tick();
    clear_srcs();
    #1;
    chk("p1_busy_low", 32'(busy), 32'h0);
    chk("p1_pkt", 32'(pkt_count), 32'h1);
    chk("p1_m_valid_low", 32'(m_valid), 32'h0);

    // fresh reset, then all four sources contend with 2-word packets
    rst = 1'b0;
    tick();
    rst = 1'b1;
    clear_plan();
    for (int i = 0; i < 4; i++) begin
      npk[i]  = 1;
      plen[i] = 2;
      gnt_q.push_back(32'(i));
      exp_q.push_back({8'(i), 8'h0, 16'h0});
      exp_q.push_back({8'(i), 8'h0, 16'h1});
    end
    run_traffic(40, 1'b0);
    #1;
    chk("rr_pkt", 32'(pkt_count), 32'h4);
    chk("rr_drop", 32'(drop_count), 32'h0);

    // stall on word 2, then a stray sop on the last word
    set_src(2, 1'b1, 1'b1, 1'b0, 32'hA1);
    tick();
    #1;
    chk("st_grant", 32'(grant_id), 32'h2);
    chk("st_w1", m_data, 32'hA1);
    tick();
    set_src(2, 1'b1, 1'b0, 1'b0, 32'hA2);
    m_ready = 1'b0;
    #1;
    chk("st_hold1_data", m_data, 32'hA2);
    chk("st_hold1_valid", 32'(m_valid), 32'h1);
    chk("st_hold1_ready", 32'(src_ready), 32'h0);
    tick();
    #1;
    chk("st_hold2_data", m_data, 32'hA2);
    chk("st_hold2_ready", 32'(src_ready), 32'h0);
    tick();
    m_ready = 1'b1;
    #1;
    chk("st_resume_data", m_data, 32'hA2);
    chk("st_resume_ready", 32'(src_ready), 32'h4);
    tick();
    set_src(2, 1'b1, 1'b1, 1'b1, 32'hA3);
    #1;
    chk("st_w3", m_data, 32'hA3);
    chk("st_w3_sop_fwd", 32'(m_sop), 32'h1);
    chk("st_err_sop_pre", 32'(err_sop), 32'h0);
    tick();
    clear_srcs();
    #1;
    chk("st_busy_low", 32'(busy), 32'h0);
    chk("st_err_sop", 32'(err_sop), 32'h1);
    chk("st_pkt", 32'(pkt_count), 32'h5);

    // orphan words from source 2 while idle
    set_src(2, 1'b1, 1'b0, 1'b0, 32'hBB);
    #1;
    chk("orph_ready", 32'(src_ready), 32'h4);
    chk("orph_m_valid", 32'(m_valid), 32'h0);
    tick();
    #1;
    chk("orph_drop1", 32'(drop_count), 32'h1);
    chk("orph_flag", 32'(err_orphan), 32'h1);
    repeat (299) tick();
    #1;
    chk("orph_sat", 32'(drop_count), 32'hFF);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    clear_srcs();
    #1;
    chk("clr_drop", 32'(drop_count), 32'h0);
    chk("clr_orphan", 32'(err_orphan), 32'h0);
    chk("clr_err_sop", 32'(err_sop), 32'h0);
    chk("clr_pkt", 32'(pkt_count), 32'h0);

    // reset in the middle of a packet from source 1
    set_src(1, 1'b1, 1'b1, 1'b0, 32'hC1);
    tick();
    tick();
    set_src(1, 1'b1, 1'b0, 1'b1, 32'hC2);
    #1;
    chk("mid_m_valid", 32'(m_valid), 32'h1);
    chk("mid_grant", 32'(grant_id), 32'h1);
    rst = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(m_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(src_ready), 32'h0);
    chk("mid_rst_grant", 32'(grant_id), 32'h0);
    tick();
    #1;
    chk("mid_rst_pkt", 32'(pkt_count), 32'h0);
    clear_srcs();
    rst = 1'b1;
    clear_plan();
    npk[0] = 1;
    npk[3] = 1;
    gnt_q.push_back(32'h0);
    gnt_q.push_back(32'h3);
    exp_q.push_back({8'h0, 8'h0, 16'h0});
    exp_q.push_back({8'h3, 8'h0, 16'h0});
    run_traffic(20, 1'b0);
    #1;
    chk("post_rst_pkt", 32'(pkt_count), 32'h2);

    // source 1 streams single-word packets, one every two cycles
    clear_plan();
    npk[1] = 4;
    for (int k = 0; k < 4; k++) begin
      gnt_q.push_back(32'h1);
      exp_q.push_back({8'h1, 8'(k), 16'h0});
    end
    run_traffic(30, 1'b1);
    #1;
    chk("stream_pkt", 32'(pkt_count), 32'h6);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    #1;
    chk("stream_clr_pkt", 32'(pkt_count), 32'h0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
